video_scandoubler: RTL and testbench
====================================

Name: video_scandoubler

Overview:
- Consumer of the raster generator's VGA counters.
- Stores each TV-rate line of pixel indices into one half of a two-bank line buffer.
- Reads the other half back twice per TV line at double rate to produce a 31 kHz stream.
- Sits between the pixel renderer and the palette/DAC stage. When VGA is off it passes TV-rate data through with identical latency.

Parameters:
- PIX_W, 8, pixel index width (palette index)
- LINE_LEN, 360, active pixels stored per line; write/read addresses >= LINE_LEN are out-of-window
- ADDR_W, 9, per-bank address width (bank select is an extra MSB)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- c3  in  1  TV pixel strobe (7 MHz enable); write cadence
- f1  in  1  VGA pixel strobe (14 MHz enable); read cadence
- vga_on  in  1  1 = scandoubled output, 0 = TV passthrough
- scanlines  in  1  enable scanline dim flag on second VGA line
- pix_in  in  PIX_W  rendered pixel for current TV position
- tv_blank  in  1  TV blanking
- vga_blank  in  1  VGA blanking
- vga_line  in  1  1 = second VGA line of current TV line
- hsync_in  in  1  selected hsync (already TV/VGA muxed)
- vsync_in  in  1  vsync
- vga_cnt_in  in  10  {bank, write address}
- vga_cnt_out  in  10  {bank, read address}
- pix_out  out  PIX_W  output pixel index
- blank_out  out  1  output blanking
- dim_out  out  1  scanline dim request
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync

Behaviour:
- Reset values:
  - pix_out = 0, blank_out = 1, dim_out = 0, hsync_out = 0, vsync_out = 0.
  - Bank-valid flags valid[1:0] = 0.
  - Buffer contents are not reset.
- Write:
  - On clk when c3 = 1 and vga_cnt_in[8:0] < LINE_LEN, write pix_in to buffer[vga_cnt_in[9:0]].
  - Out-of-window addresses perform no write.
- Bank completion:
  - When a write occurs at address LINE_LEN-1, set valid[vga_cnt_in[9]] = 1.
  - valid bits clear only on reset.
- Read, stage 1:
  - When f1 = 1, register the read address from vga_cnt_out.
  - RAM output is available the next clk (synchronous read).
- Read, stage 2:
  - rd_pix = RAM data if valid[bank] = 1 and the address is < LINE_LEN; else 0.
- Ports and collisions:
  - Simultaneous c3 and f1 are both serviced (true dual port: 1 write port, 1 read port).
  - Same-address collision (only possible transiently after a mode change) returns old data (read-first).
- Output pipeline: fixed 2-clk latency from input sample to outputs, for all outputs and both modes.
- vga_on = 1:
  - pix_out = rd_pix.
  - blank_out = vga_blank delayed 2 clk.
  - dim_out = scanlines & vga_line delayed 2 clk.
- vga_on = 0:
  - pix_out = pix_in delayed 2 clk.
  - blank_out = tv_blank delayed 2 clk.
  - dim_out = 0.
- hsync_out / vsync_out: hsync_in / vsync_in delayed 2 clk in both modes.
- Mode switch: vga_on is sampled at pipeline stage 1 and carried with the data, so no output mixes stages from the two modes.
- Blanking overrides pixel: when blank_out = 1, pix_out = 0.
- Reset mid-line: pipeline flushes to the reset values in the same clk. The next line is output as 0 until its bank is re-marked valid.

Decomposition:
- Shared package video_pkg:
  - LINE_LEN, PIX_W, ADDR_W constants.
  - Pipeline-latency constant SD_LAT = 2, used by the palette stage for alignment.
- One natural sub-module, video_linebuf: 2^(ADDR_W+1) x PIX_W simple dual-port RAM.
  - Write: enable, addr, data.
  - Read: enable, addr, registered data out, read-first.
  - Infers block RAM.

Test Plan:
- Reset, then 10 clk with vga_on=1 and f1 toggling -> pix_out=0, blank_out=1 throughout; valid=00.
- vga_on=1: write bank 0 addresses 0..359 with pix_in=addr[7:0], then read bank 0 addr 5 on f1 -> pix_out=0x05 exactly 2 clk later; addr 359 -> 0x67.
- Read bank 1 before it is ever filled -> pix_out=0. Write address 400 with c3 -> no RAM change; read of address 400 returns 0.
- vga_on=0: pix_in 0xA5 for one clk with tv_blank=0 -> pix_out=0xA5 2 clk later; hsync_in pulse -> hsync_out pulse 2 clk later with the same width.
- scanlines=1, vga_line toggles 0->1 mid TV line, vga_on=1 -> dim_out rises 2 clk after vga_line; with vga_on=0 dim_out stays 0.
- Simultaneous c3 write to bank 0 addr 10 and f1 read of bank 1 addr 10 (both banks valid) -> both complete; the read returns the bank-1 value and the bank-0 write is visible on the next read of bank 0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg
// Shared constants, types and helpers for the scandoubler and the stages
// around it.
//   PIX_W     : palette-index width carried through the video path
//   LINE_LEN  : active pixels stored per TV line
//   ADDR_W    : per-bank line-buffer address width (bank select is one more MSB)
//   SD_LAT    : input-to-output latency of the scandoubler; the palette stage
//               uses this to align sideband signals
package video_pkg;

    localparam int PIX_W    = 8;
    localparam int LINE_LEN = 360;
    localparam int ADDR_W   = 9;
    localparam int SD_LAT   = 2;

    // First out-of-window address and the last address of a line.
    localparam logic [ADDR_W-1:0] LINE_LIMIT = ADDR_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LINE_LEN - 1);

    // Stage-1 snapshot: everything sampled on the same clock travels together,
    // so a mode change never mixes fields from the two modes.
    typedef struct packed {
        logic              vga;
        logic              blank;
        logic [PIX_W-1:0]  tv_pix;
        logic              dim;
        logic              hsync;
        logic              vsync;
        logic [ADDR_W:0]   rd_addr;
    } sd_stage_t;

    localparam sd_stage_t STAGE_RST = '{
        vga:     1'b0,
        blank:   1'b1,
        tv_pix:  {PIX_W{1'b0}},
        dim:     1'b0,
        hsync:   1'b0,
        vsync:   1'b0,
        rd_addr: {(ADDR_W+1){1'b0}}
    };

    // True when a per-bank address falls inside the stored part of a line.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr);
        in_window = (addr < LINE_LIMIT);
    endfunction

endpackage

// File: rtl/video_linebuf.sv
// video_linebuf
// Simple dual-port line buffer: one write port, one read port, registered
// read data. A read and a write to the same address on the same clock return
// the old contents (read-first). Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, addr}
//   wdata : write data
//   re    : read enable
//   raddr : read address {bank, addr}
//   rdata : registered read data, valid the clock after re
module video_linebuf
    import video_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int AW     = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];

    // Single process for both ports so the read samples the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/video_scandoubler.sv
// video_scandoubler
// Writes each TV-rate line of palette indices into one bank of a two-bank
// line buffer and reads the other bank back twice per TV line at VGA rate.
// With vga_on low the TV-rate pixel stream passes through with the same
// two-clock latency as the doubled path.
//   clk, rst     : clock, synchronous active-high reset
//   c3, f1       : TV (write) and VGA (read) pixel strobes
//   vga_on       : 1 = doubled output, 0 = TV passthrough
//   scanlines    : request dimming of the second VGA line
//   pix_in       : rendered pixel for the current TV position
//   tv_blank     : TV blanking
//   vga_blank    : VGA blanking
//   vga_line     : second VGA line of the current TV line
//   hsync_in     : selected hsync
//   vsync_in     : vsync
//   vga_cnt_in   : {bank, write address}
//   vga_cnt_out  : {bank, read address}
//   pix_out      : output palette index (forced to 0 while blanked)
//   blank_out    : output blanking
//   dim_out      : scanline dim request
//   hsync_out    : delayed hsync
//   vsync_out    : delayed vsync
module video_scandoubler
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              c3,
    input  logic              f1,
    input  logic              vga_on,
    input  logic              scanlines,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              tv_blank,
    input  logic              vga_blank,
    input  logic              vga_line,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [ADDR_W:0]   vga_cnt_in,
    input  logic [ADDR_W:0]   vga_cnt_out,
    output logic [PIX_W-1:0]  pix_out,
    output logic              blank_out,
    output logic              dim_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    logic             we_s;
    logic             re_s;
    logic [PIX_W-1:0] ram_q_s;
    logic [PIX_W-1:0] rd_pix_s;
    logic [1:0]       valid_r;
    sd_stage_t        stage_r;

    // Port enables: writes only inside the stored window; reads frozen in
    // reset so the RAM output stays paired with the stage-1 read address.
    always_comb begin
        we_s = 1'b0;
        re_s = 1'b0;
        if (c3 && in_window(vga_cnt_in[ADDR_W-1:0])) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
        re_s = f1 & ~rst;
    end

    video_linebuf #(
        .DATA_W (PIX_W),
        .AW     (ADDR_W + 1)
    ) u_linebuf (
        .clk   (clk),
        .we    (we_s),
        .waddr (vga_cnt_in),
        .wdata (pix_in),
        .re    (re_s),
        .raddr (vga_cnt_out),
        .rdata (ram_q_s)
    );

    // A bank becomes readable once its last pixel has been written; only
    // reset clears it, so a partly refilled bank keeps showing old pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 2'b00;
        end else if (we_s && (vga_cnt_in[ADDR_W-1:0] == LAST_ADDR)) begin
            valid_r[vga_cnt_in[ADDR_W]] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Stage 1: sample mode, sideband and read address together.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= STAGE_RST;
        end else begin
            stage_r.vga    <= vga_on;
            stage_r.blank  <= vga_on ? vga_blank : tv_blank;
            stage_r.tv_pix <= pix_in;
            stage_r.dim    <= vga_on & scanlines & vga_line;
            stage_r.hsync  <= hsync_in;
            stage_r.vsync  <= vsync_in;
            if (f1) begin
                stage_r.rd_addr <= vga_cnt_out;
            end else begin
                stage_r.rd_addr <= stage_r.rd_addr;
            end
        end
    end

    // Doubled pixel: only a completed bank and an in-window address yield data.
    always_comb begin
        rd_pix_s = {PIX_W{1'b0}};
        if (valid_r[stage_r.rd_addr[ADDR_W]] && in_window(stage_r.rd_addr[ADDR_W-1:0])) begin
            rd_pix_s = ram_q_s;
        end else begin
            rd_pix_s = {PIX_W{1'b0}};
        end
    end

    // Stage 2: registered outputs; blanking forces the pixel to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out   <= {PIX_W{1'b0}};
            blank_out <= 1'b1;
            dim_out   <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            blank_out <= stage_r.blank;
            dim_out   <= stage_r.dim;
            hsync_out <= stage_r.hsync;
            vsync_out <= stage_r.vsync;
            if (stage_r.blank) begin
                pix_out <= {PIX_W{1'b0}};
            end else if (stage_r.vga) begin
                pix_out <= rd_pix_s;
            end else begin
                pix_out <= stage_r.tv_pix;
            end
        end
    end

endmodule

// File: tb/tb_video_scandoubler.sv
// tb_video_scandoubler
// Directed steps plus a randomized phase. A behavioural model (line memory
// array, per-bank completion flags, a two-deep record of sampled inputs)
// predicts every output on every clock; directed steps add explicit
// constant checks for the key cases.
module tb_video_scandoubler;

    localparam int LL = 360;

    logic       clk = 1'b0;
    logic       rst, c3, f1, vga_on, scanlines;
    logic [7:0] pix_in;
    logic       tv_blank, vga_blank, vga_line, hsync_in, vsync_in;
    logic [9:0] vga_cnt_in, vga_cnt_out;
    logic [7:0] pix_out;
    logic       blank_out, dim_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    video_scandoubler dut (
        .clk         (clk),
        .rst         (rst),
        .c3          (c3),
        .f1          (f1),
        .vga_on      (vga_on),
        .scanlines   (scanlines),
        .pix_in      (pix_in),
        .tv_blank    (tv_blank),
        .vga_blank   (vga_blank),
        .vga_line    (vga_line),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .vga_cnt_in  (vga_cnt_in),
        .vga_cnt_out (vga_cnt_out),
        .pix_out     (pix_out),
        .blank_out   (blank_out),
        .dim_out     (dim_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit       vga;
        bit       blank;
        bit [7:0] tvpix;
        bit       dim;
        bit       hs;
        bit       vs;
        bit [9:0] raddr;
    } rec_t;

    logic [7:0] mmem [0:1023];
    bit   [1:0] mvalid;
    logic [7:0] mrd;
    rec_t       rec;
    logic [7:0] e_pix;
    bit         e_blank, e_dim, e_hs, e_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the outputs after this edge, advance the model,
    // clock the DUT and compare.
    task automatic tick();
        if (rst) begin
            e_pix = 8'h00; e_blank = 1'b1; e_dim = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
            mvalid = 2'b00;
            rec.vga = 1'b0; rec.blank = 1'b1; rec.tvpix = 8'h00; rec.dim = 1'b0;
            rec.hs = 1'b0; rec.vs = 1'b0; rec.raddr = 10'd0;
        end else begin
            e_blank = rec.blank;
            e_dim   = rec.dim;
            e_hs    = rec.hs;
            e_vs    = rec.vs;
            if (rec.blank)
                e_pix = 8'h00;
            else if (!rec.vga)
                e_pix = rec.tvpix;
            else if (mvalid[rec.raddr[9]] && (int'(rec.raddr[8:0]) < LL))
                e_pix = mrd;
            else
                e_pix = 8'h00;
            rec.vga   = vga_on;
            rec.blank = vga_on ? vga_blank : tv_blank;
            rec.tvpix = pix_in;
            rec.dim   = vga_on & scanlines & vga_line;
            rec.hs    = hsync_in;
            rec.vs    = vsync_in;
            if (f1) begin
                rec.raddr = vga_cnt_out;
                mrd = mmem[vga_cnt_out];
            end
        end
        if (c3 && (int'(vga_cnt_in[8:0]) < LL)) begin
            mmem[vga_cnt_in] = pix_in;
            if (!rst && (int'(vga_cnt_in[8:0]) == LL - 1))
                mvalid[vga_cnt_in[9]] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pix_out",   pix_out,   e_pix);
        chk("blank_out", blank_out, e_blank);
        chk("dim_out",   dim_out,   e_dim);
        chk("hsync_out", hsync_out, e_hs);
        chk("vsync_out", vsync_out, e_vs);
    endtask

    // Fill one bank in order; reads meanwhile target the other bank.
    task automatic fill(input bit bank, input logic [7:0] xr);
        for (int a = 0; a < LL; a++) begin
            c3 = 1'b1;
            vga_cnt_in = {bank, 9'(a)};
            pix_in = 8'(a) ^ xr;
            f1 = 1'b1;
            vga_cnt_out = {~bank, 9'($urandom_range(0, 511))};
            vga_blank = ($urandom_range(0, 7) == 0);
            tick();
            c3 = 1'b0;
            f1 = 1'b0;
            tick();
        end
    endtask

    // Directed read through the doubled path: strobe, one more clock, check.
    task automatic read_chk(input string tag, input logic [9:0] addr, input logic [7:0] exp);
        f1 = 1'b1;
        vga_cnt_out = addr;
        tick();
        f1 = 1'b0;
        tick();
        chk(tag, pix_out, exp);
    endtask

    bit hs_seen [0:5];

    initial begin
        rst = 1'b1; c3 = 1'b0; f1 = 1'b0; vga_on = 1'b1; scanlines = 1'b0;
        pix_in = 8'h00; tv_blank = 1'b1; vga_blank = 1'b1; vga_line = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; vga_cnt_in = 10'd0; vga_cnt_out = 10'd0;
        mvalid = 2'b00; mrd = 8'h00;

        // Reset values.
        repeat (3) tick();
        chk("reset_pix",   pix_out,   8'h00);
        chk("reset_blank", blank_out, 1'b1);

        // Ten clocks of VGA mode with nothing stored.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            f1 = i[0];
            vga_cnt_out = 10'($urandom_range(0, 1023));
            tick();
            chk("idle_pix",   pix_out,   8'h00);
            chk("idle_blank", blank_out, 1'b1);
        end

        // Bank 0 holds pix = addr[7:0].
        vga_blank = 1'b0;
        fill(1'b0, 8'h00);
        vga_blank = 1'b0;
        read_chk("rd_b0_a5",   10'd5,   8'h05);
        read_chk("rd_b0_a359", 10'd359, 8'h67);
        read_chk("rd_b1_empty", {1'b1, 9'd5}, 8'h00);

        // Out-of-window write is ignored; out-of-window read is zero.
        c3 = 1'b1; vga_cnt_in = 10'd400; pix_in = 8'hFF;
        tick();
        c3 = 1'b0;
        read_chk("rd_oow_400", 10'd400, 8'h00);
        read_chk("rd_b0_a144", 10'd144, 8'h90);

        // TV passthrough.
        vga_on = 1'b0; tv_blank = 1'b0; pix_in = 8'h00;
        tick();
        pix_in = 8'hA5;
        tick();
        pix_in = 8'h00;
        tick();
        chk("tv_pix_a5", pix_out, 8'hA5);
        tick();
        chk("tv_pix_after", pix_out, 8'h00);

        // hsync pulse of three clocks comes out three clocks wide, delayed.
        for (int i = 0; i < 6; i++) begin
            hsync_in = (i < 3);
            tick();
            hs_seen[i] = hsync_out;
        end
        chk("hs0", hs_seen[0], 1'b0);
        chk("hs1", hs_seen[1], 1'b1);
        chk("hs3", hs_seen[3], 1'b1);
        chk("hs4", hs_seen[4], 1'b0);

        // Scanline dim.
        vga_on = 1'b1; scanlines = 1'b1; vga_line = 1'b0;
        tick(); tick();
        vga_line = 1'b1;
        tick();
        chk("dim_lat1", dim_out, 1'b0);
        tick();
        chk("dim_rise", dim_out, 1'b1);
        vga_on = 1'b0;
        tick(); tick();
        chk("dim_tv", dim_out, 1'b0);
        vga_on = 1'b1; vga_line = 1'b0;

        // Bank 1 holds pix = addr[7:0] ^ 0x5A.
        fill(1'b1, 8'h5A);
        vga_blank = 1'b0;

        // Simultaneous write to bank 0 and read from bank 1.
        c3 = 1'b1; vga_cnt_in = 10'd10; pix_in = 8'hEE;
        f1 = 1'b1; vga_cnt_out = {1'b1, 9'd10};
        tick();
        c3 = 1'b0; f1 = 1'b0;
        tick();
        chk("coll_rd_b1", pix_out, 8'h50);
        read_chk("coll_wr_b0", 10'd10, 8'hEE);

        // Same-address collision returns the old value.
        c3 = 1'b1; vga_cnt_in = 10'd20; pix_in = 8'h11;
        f1 = 1'b1; vga_cnt_out = 10'd20;
        tick();
        c3 = 1'b0; f1 = 1'b0;
        tick();
        chk("rd_first_old", pix_out, 8'h14);
        read_chk("rd_first_new", 10'd20, 8'h11);

        // Randomized phase, checked against the model on every clock.
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            c3         = $urandom_range(0, 1) == 1;
            f1         = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 63) == 0) vga_on = ~vga_on;
            scanlines  = $urandom_range(0, 1) == 1;
            vga_line   = $urandom_range(0, 1) == 1;
            pix_in     = 8'($urandom);
            tv_blank   = ($urandom_range(0, 5) == 0);
            vga_blank  = ($urandom_range(0, 5) == 0);
            hsync_in   = $urandom_range(0, 1) == 1;
            vsync_in   = $urandom_range(0, 1) == 1;
            vga_cnt_in = ($urandom_range(0, 15) == 0) ? {1'($urandom), 9'd359}
                                                      : 10'($urandom_range(0, 1023));
            vga_cnt_out = 10'($urandom_range(0, 1023));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
